// File: rtl/ramarb_pkg.sv
// ramarb_pkg: shared types and width helper for the ssram_port_arbiter slice.
package ramarb_pkg;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    typedef logic owner_t;

    function automatic int clog2_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ramarb_rr_picker.sv
// ramarb_rr_picker: combinational owner selection between two requesters.
// RAMARB_FIXED_PRIORITY_EN makes requester 0 always win a tie.
module ramarb_rr_picker
    import ramarb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t lastOwner,
    output logic   valid,
    output owner_t owner
);

    assign valid = req0 | req1;

`ifdef RAMARB_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = lastOwner;
    assign owner = ~req0;
`else
    assign owner = (req0 & req1) ? ~lastOwner : req1;
`endif

endmodule

// File: rtl/ssram_port_arbiter.sv
// ssram_port_arbiter: burst arbiter sharing one synchronous SRAM port between two requesters.
// Define RAMARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module ssram_port_arbiter
    import ramarb_pkg::*;
#(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512,
    parameter int maxBurst    = 16,
    localparam int AW = clog2_w(nrOfEntries),
    localparam int BW = clog2_w(maxBurst + 1)
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                req0,
    input  logic                req1,
    input  logic                write0,
    input  logic                write1,
    input  logic [AW-1:0]       addr0,
    input  logic [AW-1:0]       addr1,
    input  logic [BW-1:0]       burst0,
    input  logic [BW-1:0]       burst1,
    input  logic [bitwidth-1:0] wData0,
    input  logic [bitwidth-1:0] wData1,
    output logic                grant0,
    output logic                grant1,
    output logic                wAck0,
    output logic                wAck1,
    output logic                rValid0,
    output logic                rValid1,
    output logic [bitwidth-1:0] rData,
    output logic                done0,
    output logic                done1,
    output logic [AW-1:0]       ramAddr,
    output logic                ramWe,
    output logic [bitwidth-1:0] ramDataIn,
    input  logic [bitwidth-1:0] ramDataOut
);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d, last_q, last_d;
    logic          write_q, write_d;
    logic [AW-1:0] base_q, base_d, addr_q, addr_d;
    logic [BW-1:0] len_q, len_d, idx_q, idx_d;

    logic          pick_valid;
    owner_t        pick_owner;
    logic [BW-1:0] burst_sel, req_len;
    logic [AW-1:0] beat_addr;
    logic          in_burst, in_drain, last_beat, rd_ret;

    ramarb_rr_picker u_picker (
        .req0      (req0),
        .req1      (req1),
        .lastOwner (last_q),
        .valid     (pick_valid),
        .owner     (pick_owner)
    );

    assign burst_sel = pick_owner ? burst1 : burst0;
    assign req_len   = (burst_sel == '0) ? BW'(1)
                     : (burst_sel > BW'(maxBurst)) ? BW'(maxBurst) : burst_sel;
    // Power-of-two depth makes truncation the wrap-around.
    assign beat_addr = base_q + AW'(idx_q);
    assign in_burst  = state_q == BURST;
    assign in_drain  = state_q == DRAIN;
    assign last_beat = idx_q == len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        write_d = write_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = BURST;
                owner_d = pick_owner;
                write_d = pick_owner ? write1 : write0;
                base_d  = pick_owner ? addr1 : addr0;
                len_d   = req_len;
                idx_d   = '0;
            end
            BURST: begin
                addr_d  = beat_addr;
                idx_d   = idx_q + 1'b1;
                state_d = last_beat ? DRAIN : BURST;
            end
            DRAIN: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            write_q <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            write_q <= write_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    // Read data trails its address by one cycle, so beat k returns in the slot of beat k+1 (or DRAIN).
    assign rd_ret    = ~write_q & ((in_burst & (idx_q != '0)) | in_drain);
    assign grant0    = in_burst & (idx_q == '0) & ~owner_q;
    assign grant1    = in_burst & (idx_q == '0) & owner_q;
    assign wAck0     = in_burst & write_q & ~owner_q;
    assign wAck1     = in_burst & write_q & owner_q;
    assign rValid0   = rd_ret & ~owner_q;
    assign rValid1   = rd_ret & owner_q;
    assign done0     = in_drain & ~owner_q;
    assign done1     = in_drain & owner_q;
    assign rData     = ramDataOut;
    assign ramAddr   = in_burst ? beat_addr : addr_q;
    assign ramWe     = in_burst & write_q;
    assign ramDataIn = owner_q ? wData1 : wData0;

endmodule

// File: doc/ssram_port_arbiter.md
Name: ssram_port_arbiter

Overview:
- Shares one port of the ramDma dual-port synchronous SRAM between two bus-side requesters, such as a DMA read engine and a CPU-side write path.
- Grants whole bursts with round-robin arbitration and sequences consecutive RAM addresses.
- Handles the SRAM's 1-cycle read latency and returns read data with a valid strobe.
- Sits between the requesters and the SRAM port pins: clock, writeEnable, address, dataIn and dataOut.

Parameters:
- bitwidth, 32, data width; must match the SRAM.
- nrOfEntries, 512, SRAM depth; must be a power of two. Address width is AW=$clog2(nrOfEntries).
- maxBurst, 16, maximum beats per burst. Length field width is BW=$clog2(maxBurst+1).

Ports:
- clock  in  1  single clock, rising edge; all state changes on this edge.
- nReset  in  1  asynchronous, active-low reset.
- req0/req1  in  1  burst request from requester 0/1.
- write0/write1  in  1  1 = write burst, 0 = read burst.
- addr0/addr1  in  AW  burst start address.
- burst0/burst1  in  BW  beat count, 1..maxBurst; 0 is treated as 1; values above maxBurst are clamped to maxBurst.
- wData0/wData1  in  bitwidth  write beat data.
- grant0/grant1  out  1  one-cycle pulse: the burst was accepted.
- wAck0/wAck1  out  1  the current write beat is consumed this cycle.
- rValid0/rValid1  out  1  rData holds a read beat.
- rData  out  bitwidth  read data, shared by both requesters; qualified by rValidX.
- done0/done1  out  1  one-cycle pulse: the burst is complete.
- ramAddr  out  AW  SRAM address.
- ramWe  out  1  SRAM write enable.
- ramDataIn  out  bitwidth  SRAM write data.
- ramDataOut  in  bitwidth  SRAM read data, valid 1 cycle after the address.

Behaviour:
- Reset (nReset=0, asynchronous): state=IDLE; all grant/wAck/rValid/done outputs are 0; ramWe=0; ramAddr=0; lastOwner=1, so requester 0 wins first.
- Reset asserted mid-burst aborts the burst immediately; no done pulse is issued.
- FSM states are IDLE, BURST and DRAIN.
- IDLE:
  - Sample req0/req1 on each edge.
  - If one is high, latch the owner plus its write/addr/burst, set beat index=0 and go to BURST.
  - If both are high, the owner is the requester that is not lastOwner.
- BURST, one beat per cycle:
  - ramAddr=(base+idx) mod nrOfEntries; wrap-around is natural truncation.
  - ramWe=latched write.
  - grantOwner=1 in the first BURST cycle only.
  - Write burst: wAckOwner=1 in every BURST cycle and ramDataIn=wDataOwner combinationally. The requester must present beat k while wAck is high and advance on that edge.
  - Read burst: ramWe=0.
  - On the last beat (idx=len-1), go to DRAIN.
- DRAIN, one cycle:
  - For a read burst, rValidOwner=1 for the final beat.
  - doneOwner=1 for both read and write bursts.
  - Set lastOwner=owner and go to IDLE.
- Read return: rValidOwner is asserted in the cycle after each read beat, and rData=ramDataOut. Beats arrive in address order, one per cycle, with no gaps.
- Timing:
  - An N-beat burst occupies N+2 cycles: IDLE decision, N beats, then DRAIN.
  - The earliest next grant comes from the IDLE cycle that follows DRAIN.
- Request hold rules:
  - The requester holds req/write/addr/burst stable until its grant.
  - Inputs are ignored while the block is busy.
  - req may stay high after grant to request a further burst; it is re-arbitrated in IDLE.
- Outputs to the non-owner stay 0 throughout.
- ramAddr holds its last value when not in BURST; ramWe=0 outside BURST.

Optional Feature:
- Macro RAMARB_FIXED_PRIORITY_EN.
- When defined: requester 0 always wins a simultaneous request, and lastOwner is not used.
- When undefined: round-robin arbitration as described above.
- Interface and timing are identical in both cases.

Decomposition:
- Package ramarb_pkg holds:
  - the state enum {IDLE, BURST, DRAIN};
  - the owner type (1 bit);
  - the helper that computes AW/BW from the parameters.
- One natural sub-module: ramarb_rr_picker. It is combinational: inputs are req0, req1 and lastOwner; outputs are a valid flag and the owner. It also contains the fixed-priority variant under the macro.

Test Plan:
- Reset, then req0=1, write0=1, addr0=510, burst0=4, wData=A..D: grant0 in cycle 1; ramAddr sequence is 510, 511, 0, 1 with ramWe=1; wAck0 is high for 4 cycles; done0 pulses at cycle 5.
- req1=1, read, addr1=510, burst1=4 after the previous test: rValid1 on 4 consecutive cycles with rData=A, B, C, D; done1 pulses with the last rValid.
- req0 and req1 both held high with burst=2 each: grants alternate 0,1,0,1; each burst is 4 cycles long.
- With RAMARB_FIXED_PRIORITY_EN defined and the same stimulus as the previous test: grant0 on every burst and grant1 never.
- burst0=0 → a single beat; burst0=maxBurst+3 → exactly maxBurst beats.
- nReset pulsed low during beat 2 of an 8-beat write: all outputs are 0 immediately; no done pulse; the next req1 is granted normally.
